// File: rtl/pipe_alu_pkg.sv
// rtl/pipe_alu_pkg.sv - opcodes and FSM states shared by the pipe_alu slice
package pipe_alu_pkg;

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_MUL    = 3'b010;
    localparam logic [2:0] OP_AND    = 3'b011;
    localparam logic [2:0] OP_XOR    = 3'b100;
    localparam logic [2:0] OP_ABS    = 3'b101;
    localparam logic [2:0] OP_SUBSHL = 3'b110;
    localparam logic [2:0] OP_RSVD   = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/pipe_alu_mul.sv
// rtl/pipe_alu_mul.sv - sequential shift-add multiplier, one multiplier bit per cycle
module pipe_alu_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk_p_i,
    input  logic               reset_n_i,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;

    logic [2*WIDTH-1:0] w_partial;
    logic [2*WIDTH-1:0] w_sum;

    assign w_partial = r_mplier[0] ? r_mcand : '0;
    assign w_sum     = r_acc + w_partial;

    // The last bit's sum is presented combinationally so the caller loads it on the retiring edge.
    assign done_o    = r_busy & (r_cnt == CW'(WIDTH - 1));
    assign busy_o    = r_busy;
    assign product_o = w_sum;

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (start_i) begin
            r_mcand  <= {{WIDTH{1'b0}}, a_i};
            r_mplier <= b_i;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
            if (done_o) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipe_alu.sv
// rtl/pipe_alu.sv - handshaked WIDTH-bit ALU with shift-add MUL; flags_o exists when PIPE_ALU_FLAGS_EN is defined
module pipe_alu
    import pipe_alu_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SHIFT_AMT = 2
) (
    input  logic               clk_p_i,
    input  logic               reset_n_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH-1:0]   data_a_i,
    input  logic [WIDTH-1:0]   data_b_i,
    input  logic [2:0]         inst_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [2*WIDTH-1:0] data_o,
`ifdef PIPE_ALU_FLAGS_EN
    output logic [1:0]         flags_o,
`endif
    output logic               err_o
);

    localparam int W2 = 2 * WIDTH;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_valid;
    logic [W2-1:0]   r_data;
    logic            r_err;

    logic            w_accept;
    logic            w_start_mul;
    logic            w_load_alu;
    logic            w_load;
    logic            w_mul_busy;
    logic            w_mul_done;
    logic [W2-1:0]   w_product;
    logic [W2-1:0]   w_a_ext;
    logic [W2-1:0]   w_b_ext;
    logic [W2-1:0]   w_diff;
    logic [WIDTH-1:0] w_a_neg;
    logic [W2-1:0]   w_res;
    logic            w_res_err;
    logic [W2-1:0]   w_load_data;

    assign in_ready_o  = (r_state == ST_IDLE) & ~w_mul_busy & (~r_valid | out_ready_i);
    assign w_accept    = in_valid_i & in_ready_o;
    assign w_start_mul = w_accept & (inst_i == OP_MUL);
    assign w_load_alu  = w_accept & (inst_i != OP_MUL);
    assign w_load      = w_load_alu | w_mul_done;

    assign w_a_ext = {{WIDTH{1'b0}}, data_a_i};
    assign w_b_ext = {{WIDTH{1'b0}}, data_b_i};
    assign w_diff  = w_b_ext - w_a_ext;
    assign w_a_neg = -data_a_i;

    always_comb begin
        w_res     = '0;
        w_res_err = 1'b0;
        case (inst_i)
            OP_ADD:    w_res = w_a_ext + w_b_ext;
            OP_SUB:    w_res = w_diff;
            OP_AND:    w_res = w_a_ext & w_b_ext;
            OP_XOR:    w_res = w_a_ext ^ w_b_ext;
            // Negating the most-negative value wraps back to 2^(W-1), which is the wanted magnitude.
            OP_ABS:    w_res = data_a_i[WIDTH-1] ? {{WIDTH{1'b0}}, w_a_neg} : w_a_ext;
            OP_SUBSHL: w_res = w_diff << SHIFT_AMT;
            OP_RSVD:   w_res_err = 1'b1;
            default:   w_res = '0;
        endcase
    end

    assign w_load_data = w_load_alu ? w_res : w_product;

    pipe_alu_mul #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk_p_i   (clk_p_i),
        .reset_n_i (reset_n_i),
        .start_i   (w_start_mul),
        .a_i       (data_a_i),
        .b_i       (data_b_i),
        .busy_o    (w_mul_busy),
        .done_o    (w_mul_done),
        .product_o (w_product)
    );

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start_mul) w_state_next = ST_MUL;
            ST_MUL:  if (w_mul_done)  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // A load wins over a transfer: that is the accept-while-draining case.
    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= w_load_data;
            r_err   <= w_load_alu & w_res_err;
        end else if (r_valid & out_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid_o = r_valid;
    assign data_o      = r_data;
    assign err_o       = r_err;

`ifdef PIPE_ALU_FLAGS_EN
    logic [1:0] r_flags;

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_flags <= 2'b00;
        end else if (w_load) begin
            r_flags <= {w_load_data[W2-1], (w_load_data == '0)};
        end
    end

    assign flags_o = r_flags;
`endif

endmodule

// File: tb/tb_pipe_alu.sv
// tb/tb_pipe_alu.sv - scoreboard bench for pipe_alu with directed vectors
module tb_pipe_alu;
    import pipe_alu_pkg::*;

    logic        clk_p_i;
    logic        reset_n_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [7:0]  data_a_i;
    logic [7:0]  data_b_i;
    logic [2:0]  inst_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] data_o;
    logic        err_o;
`ifdef PIPE_ALU_FLAGS_EN
    logic [1:0]  flags_o;
`endif

    typedef struct {
        logic [15:0] d;
        logic        e;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    pipe_alu #(.WIDTH(8), .SHIFT_AMT(2)) dut (
        .clk_p_i     (clk_p_i),
        .reset_n_i   (reset_n_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .data_a_i    (data_a_i),
        .data_b_i    (data_b_i),
        .inst_i      (inst_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .data_o      (data_o),
`ifdef PIPE_ALU_FLAGS_EN
        .flags_o     (flags_o),
`endif
        .err_o       (err_o)
    );

    initial clk_p_i = 1'b0;
    always #5 clk_p_i = ~clk_p_i;
    always @(posedge clk_p_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Issues one op; chk_lat records the expected transfer cycle, push=0 drops the result.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] ed, input logic ee, input bit chk_lat, input bit push);
        int n;
        exp_t x;
        n = 0;
        @(negedge clk_p_i);
        in_valid_i = 1'b1;
        inst_i     = op;
        data_a_i   = a;
        data_b_i   = b;
        #1;
        while (!in_ready_o && n < 200) begin
            @(negedge clk_p_i);
            #1;
            n++;
        end
        if (!in_ready_o) begin
            chk("issue_timeout", 32'(in_ready_o), 32'd1);
        end else if (push) begin
            x.d   = ed;
            x.e   = ee;
            x.due = chk_lat ? (cyc + ((op == OP_MUL) ? 9 : 1)) : 0;
            sb.push_back(x);
        end
        @(posedge clk_p_i);
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk_p_i);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
        @(negedge clk_p_i);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_p_i);
            #2;
            if (reset_n_i && out_valid_o && out_ready_i) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 32'(data_o), 32'hDEAD_BEEF);
                end else begin
                    e = sb.pop_front();
                    chk("data", 32'(data_o), 32'(e.d));
                    chk("err", 32'(err_o), 32'(e.e));
                    if (e.due != 0) chk("latency_cycle", 32'(cyc), 32'(e.due));
`ifdef PIPE_ALU_FLAGS_EN
                    chk("flags", 32'(flags_o), 32'({e.d[15], (e.d == 16'h0)}));
`endif
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_expired cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        exp_t x;
        reset_n_i   = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        data_a_i    = '0;
        data_b_i    = '0;
        inst_i      = '0;
        repeat (2) @(negedge clk_p_i);
        #1;
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_data", 32'(data_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_in_ready", 32'(in_ready_o), 32'd1);
        @(negedge clk_p_i);
        reset_n_i = 1'b1;

        issue(OP_ADD,    8'hFF, 8'h01, 16'h0100, 1'b0, 1, 1);
        issue(OP_SUB,    8'h05, 8'h03, 16'hFFFE, 1'b0, 1, 1);
        issue(OP_ABS,    8'h80, 8'h00, 16'h0080, 1'b0, 1, 1);
        issue(OP_ABS,    8'hFB, 8'h00, 16'h0005, 1'b0, 1, 1);
        issue(OP_SUBSHL, 8'h01, 8'h03, 16'h0008, 1'b0, 1, 1);
        issue(OP_SUBSHL, 8'h03, 8'h01, 16'hFFF8, 1'b0, 1, 1);
        issue(OP_RSVD,   8'h12, 8'h34, 16'h0000, 1'b1, 1, 1);
        issue(OP_AND,    8'hF0, 8'h3C, 16'h0030, 1'b0, 1, 1);
        issue(OP_XOR,    8'hF0, 8'h3C, 16'h00CC, 1'b0, 1, 1);
        drain();

        issue(OP_MUL, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_p_i);
            #1;
            chk("mul_in_ready_low", 32'(in_ready_o), 32'd0);
        end
        issue(OP_MUL, 8'h0D, 8'h0B, 16'h008F, 1'b0, 1, 1);
        drain();

        @(negedge clk_p_i);
        out_ready_i = 1'b0;
        issue(OP_ADD, 8'h11, 8'h22, 16'h0033, 1'b0, 0, 1);
        @(negedge clk_p_i);
        in_valid_i = 1'b1;
        inst_i     = OP_AND;
        data_a_i   = 8'hF0;
        data_b_i   = 8'h3C;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_in_ready", 32'(in_ready_o), 32'd0);
            chk("stall_valid", 32'(out_valid_o), 32'd1);
            chk("stall_data", 32'(data_o), 32'h0033);
            @(negedge clk_p_i);
        end
        out_ready_i = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready_o), 32'd1);
        x.d = 16'h0030; x.e = 1'b0; x.due = cyc + 1;
        sb.push_back(x);
        @(posedge clk_p_i);
        #1;
        in_valid_i = 1'b0;
        drain();

        issue(OP_ADD, 8'h12, 8'h34, 16'h0046, 1'b0, 1, 1);
        issue(OP_XOR, 8'hAA, 8'h55, 16'h00FF, 1'b0, 1, 1);
        issue(OP_SUB, 8'h01, 8'h00, 16'hFFFF, 1'b0, 1, 1);
        issue(OP_ABS, 8'h7F, 8'h00, 16'h007F, 1'b0, 1, 1);
        drain();

        issue(OP_SUB, 8'h10, 8'h10, 16'h0000, 1'b0, 1, 1);
        issue(OP_SUB, 8'h02, 8'h01, 16'hFFFF, 1'b0, 1, 1);
        drain();

        issue(OP_MUL, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 0, 0);
        repeat (3) @(negedge clk_p_i);
        reset_n_i = 1'b0;
        #1;
        chk("midmul_rst_valid", 32'(out_valid_o), 32'd0);
        chk("midmul_rst_data", 32'(data_o), 32'd0);
        chk("midmul_rst_err", 32'(err_o), 32'd0);
        @(negedge clk_p_i);
        reset_n_i = 1'b1;
        #1;
        chk("midmul_release_ready", 32'(in_ready_o), 32'd1);
        repeat (12) @(negedge clk_p_i);
        #1;
        chk("midmul_no_stale", 32'(out_valid_o), 32'd0);

        issue(OP_ADD, 8'h01, 8'h02, 16'h0003, 1'b0, 1, 1);
        drain();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
